// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared constants and types for the FIFO write-port arbiter.
//   DATA_WIDTH : FIFO word width
//   NUM_REQ    : number of producers sharing the write port (2..8)
//   MAX_BURST  : words accepted per grant (power of two, >= 2)
package fifo_wr_arbiter_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int NUM_REQ    = 4;
   localparam int MAX_BURST  = 8;

   localparam int REQ_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Producer index increment; wraps explicitly so non-power-of-two
   // NUM_REQ never lands on a nonexistent producer.
   function automatic logic [REQ_W-1:0] wrap_inc(input logic [REQ_W-1:0] v);
      return (v == REQ_W'(NUM_REQ-1)) ? '0 : v + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles producer-side handshake and FIFO write-port signals.
//   master : arbiter side (drives gnt/ack/winc/wdata/busy)
//   slave  : producers + FIFO side (drives req/req_data/req_last/wfull)
interface fifo_wr_arbiter_if;
   import fifo_wr_arbiter_pkg::*;

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            ack;
   logic                          wfull;
   logic                          winc;
   logic [DATA_WIDTH-1:0]         wdata;
   logic                          busy;

   modport master (
      input  req, req_data, req_last, wfull,
      output gnt, ack, winc, wdata, busy
   );

   modport slave (
      output req, req_data, req_last, wfull,
      input  gnt, ack, winc, wdata, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority selector.
//   req   : request vector
//   ptr   : highest-priority index this round
//   valid : any request present
//   idx   : first set request at or after ptr, wrapping modulo N
module rr_pick #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   // Scan from farthest to nearest so the nearest hit overwrites the rest.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N])
            idx = W'((int'(ptr) + k) % N);
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the async FIFO write port among NUM_REQ
//   producers, in bursts of up to MAX_BURST words.
//   wclk   : write-domain clock
//   wrst_n : asynchronous active-low reset
//   bus    : producer req/req_data/req_last/gnt/ack, FIFO wfull/winc/wdata, busy
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; arbitrate among requests, no writes this cycle
//   BURST | owner holds the write port until last word, cap, or req drop
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
(
   input  logic              wclk,
   input  logic              wrst_n,
   fifo_wr_arbiter_if.master bus
);

   arb_state_e         state, state_nxt;
   logic [REQ_W-1:0]   owner, owner_nxt;
   logic [REQ_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
   logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
   logic               busy_q, busy_nxt;

   logic               pick_valid;
   logic [REQ_W-1:0]   pick_idx;
   logic               accept;
   logic               burst_end;
   logic               winc_c;
   logic [NUM_REQ-1:0] ack_c;
   logic [DATA_WIDTH-1:0] wdata_c;

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req   (bus.req),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
         gnt_q     <= gnt_nxt;
         busy_q    <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      gnt_nxt       = gnt_q;
      busy_nxt      = busy_q;
      accept        = 1'b0;
      burst_end     = 1'b0;
      winc_c        = 1'b0;
      ack_c         = '0;
      wdata_c       = '0;

      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nxt          = BURST;
               owner_nxt          = pick_idx;
               burst_cnt_nxt      = '0;
               gnt_nxt            = '0;
               gnt_nxt[pick_idx]  = 1'b1;
               busy_nxt           = 1'b1;
            end
         end
         BURST: begin
            // wfull is registered by the FIFO, so gating here is glitch-free
            accept         = bus.req[owner] & ~bus.wfull;
            winc_c         = accept;
            ack_c[owner]   = accept;
            wdata_c        = bus.req_data[owner*DATA_WIDTH +: DATA_WIDTH];
            // A dropped request releases even while stalled on full.
            burst_end = ~bus.req[owner] |
                        (accept & (bus.req_last[owner] |
                                   (burst_cnt == CNT_W'(MAX_BURST-1))));
            if (accept)
               burst_cnt_nxt = burst_cnt + 1'b1;
            if (burst_end) begin
               state_nxt     = IDLE;
               gnt_nxt       = '0;
               busy_nxt      = 1'b0;
               burst_cnt_nxt = '0;
               rr_ptr_nxt    = wrap_inc(owner);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.gnt   = gnt_q;
   assign bus.busy  = busy_q;
   assign bus.winc  = winc_c;
   assign bus.ack   = ack_c;
   assign bus.wdata = wdata_c;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench: a per-cycle vector table for single-producer and
//   round-robin traffic, plus hand sequences for burst cap, full stall,
//   owner drop and reset mid-burst.
module tb_fifo_wr_arbiter;
   import fifo_wr_arbiter_pkg::*;

   logic wclk   = 1'b0;
   logic wrst_n = 1'b0;
   always #5 wclk = ~wclk;

   fifo_wr_arbiter_if bus();

   fifo_wr_arbiter dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  last;
      logic        wfull;
      logic [31:0] data;
      logic [3:0]  gnt;
      logic [3:0]  ack;
      logic [7:0]  wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic [3:0] req,
                               input logic [3:0] last, input logic wfull,
                               input logic [31:0] data, input logic [3:0] gnt,
                               input logic [3:0] ack, input logic [7:0] wdata);
      vec_t v;
      v.rst = rst; v.req = req; v.last = last; v.wfull = wfull;
      v.data = data; v.gnt = gnt; v.ack = ack; v.wdata = wdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] last,
                        input logic wfull, input logic [31:0] data);
      bus.req      = req;
      bus.req_last = last;
      bus.wfull    = wfull;
      bus.req_data = data;
   endtask

   // Leaves the bench at posedge+1, the phase where inputs are driven.
   task automatic do_reset();
      drive(4'b0, 4'b0, 1'b0, 32'h0);
      wrst_n = 1'b0;
      repeat (2) @(posedge wclk);
      #1 wrst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge wclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] got;
      logic [29:0] exp_pat;
      int w;

      drive(4'b0, 4'b0, 1'b0, 32'h0);
      #1;
      chk("reset_gnt",   32'(bus.gnt),   32'h0);
      chk("reset_busy",  32'(bus.busy),  32'h0);
      chk("reset_winc",  32'(bus.winc),  32'h0);
      chk("reset_wdata", 32'(bus.wdata), 32'h0);

      // Single producer 2: three words, last on the third.
      vecs.push_back(mk(1, 4'b0100, 4'b0000, 0, 32'h00_21_00_00, 4'b0000, 4'b0000, 8'h00));
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 32'h00_21_00_00, 4'b0100, 4'b0100, 8'h21));
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 32'h00_22_00_00, 4'b0100, 4'b0100, 8'h22));
      vecs.push_back(mk(0, 4'b0100, 4'b0100, 0, 32'h00_23_00_00, 4'b0100, 4'b0100, 8'h23));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h00_00_00_00, 4'b0000, 4'b0000, 8'h00));
      // Round robin from reset: all request, last on every 2nd word.
      vecs.push_back(mk(1, 4'b1111, 4'b0000, 0, 32'h31_21_11_01, 4'b0000, 4'b0000, 8'h00));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31_21_11_01, 4'b0001, 4'b0001, 8'h01));
      vecs.push_back(mk(0, 4'b1111, 4'b0001, 0, 32'h31_21_11_02, 4'b0001, 4'b0001, 8'h02));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31_21_11_03, 4'b0000, 4'b0000, 8'h00));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31_21_11_03, 4'b0010, 4'b0010, 8'h11));
      vecs.push_back(mk(0, 4'b1111, 4'b0010, 0, 32'h31_21_12_03, 4'b0010, 4'b0010, 8'h12));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31_21_13_03, 4'b0000, 4'b0000, 8'h00));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31_21_13_03, 4'b0100, 4'b0100, 8'h21));
      vecs.push_back(mk(0, 4'b1111, 4'b0100, 0, 32'h31_22_13_03, 4'b0100, 4'b0100, 8'h22));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31_23_13_03, 4'b0000, 4'b0000, 8'h00));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31_23_13_03, 4'b1000, 4'b1000, 8'h31));
      vecs.push_back(mk(0, 4'b1111, 4'b1000, 0, 32'h32_23_13_03, 4'b1000, 4'b1000, 8'h32));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h33_23_13_03, 4'b0000, 4'b0000, 8'h00));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h33_23_13_03, 4'b0001, 4'b0001, 8'h03));
      vecs.push_back(mk(0, 4'b1111, 4'b0001, 0, 32'h33_23_13_04, 4'b0001, 4'b0001, 8'h04));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h00_00_00_00, 4'b0000, 4'b0000, 8'h00));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         drive(vecs[i].req, vecs[i].last, vecs[i].wfull, vecs[i].data);
         #3;
         chk($sformatf("vec%0d_gnt", i),   32'(bus.gnt),   32'(vecs[i].gnt));
         chk($sformatf("vec%0d_ack", i),   32'(bus.ack),   32'(vecs[i].ack));
         chk($sformatf("vec%0d_winc", i),  32'(bus.winc),  32'(|vecs[i].ack));
         chk($sformatf("vec%0d_wdata", i), 32'(bus.wdata), 32'(vecs[i].wdata));
         chk($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(|vecs[i].gnt));
         next_cycle();
      end

      // Burst cap: producer 0 streams 20 words with no last marker.
      do_reset();
      w = 0;
      got = '0;
      exp_pat = '0;
      for (int c = 1;  c <= 8;  c++) exp_pat[c] = 1'b1;
      for (int c = 10; c <= 17; c++) exp_pat[c] = 1'b1;
      for (int c = 19; c <= 22; c++) exp_pat[c] = 1'b1;
      for (int c = 0; c < 30; c++) begin
         drive((w < 20) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, {24'h0, 8'(w)});
         #3;
         got[c] = bus.winc;
         if (bus.winc) begin
            chk("cap_wdata", 32'(bus.wdata), 32'(w));
            w++;
         end
         next_cycle();
      end
      chk("cap_pattern", 32'(got), 32'(exp_pat));
      chk("cap_words", 32'(w), 32'd20);

      // Full stall: producer 1 sends 5 words, wfull high for cycles 3..7.
      do_reset();
      w = 0;
      got = '0;
      exp_pat = '0;
      exp_pat[1] = 1'b1; exp_pat[2] = 1'b1;
      exp_pat[8] = 1'b1; exp_pat[9] = 1'b1; exp_pat[10] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         drive((w < 5) ? 4'b0010 : 4'b0000, (w == 4) ? 4'b0010 : 4'b0000,
               (c >= 3 && c < 8), {16'h0, 8'(8'h40 + w), 8'h0});
         #3;
         got[c] = bus.winc;
         if (c >= 3 && c < 8) begin
            chk("stall_winc", 32'(bus.winc), 32'h0);
            chk("stall_ack",  32'(bus.ack),  32'h0);
            chk("stall_cnt",  32'(dut.burst_cnt), 32'd2);
            chk("stall_gnt",  32'(bus.gnt),  32'h2);
         end
         if (bus.winc) begin
            chk("stall_wdata", 32'(bus.wdata), 32'(8'h40 + w));
            w++;
         end
         next_cycle();
      end
      chk("stall_pattern", 32'(got), 32'(exp_pat));
      chk("stall_words", 32'(w), 32'd5);

      // Owner drop: producer 3 releases mid-burst, pending producer 1 wins next.
      do_reset();
      drive(4'b1000, 4'b0000, 1'b0, 32'h30_00_10_00);
      #3 chk("drop_c0_gnt", 32'(bus.gnt), 32'h0);
      next_cycle();
      drive(4'b1010, 4'b0000, 1'b0, 32'h30_00_10_00);
      #3 chk("drop_c1_ack", 32'(bus.ack), 32'h8);
      chk("drop_c1_wdata", 32'(bus.wdata), 32'h30);
      next_cycle();
      drive(4'b1010, 4'b0000, 1'b0, 32'h31_00_10_00);
      #3 chk("drop_c2_ack", 32'(bus.ack), 32'h8);
      next_cycle();
      drive(4'b0010, 4'b0000, 1'b0, 32'h31_00_10_00);
      #3 chk("drop_c3_winc", 32'(bus.winc), 32'h0);
      chk("drop_c3_gnt", 32'(bus.gnt), 32'h8);
      next_cycle();
      #3 chk("drop_c4_gnt", 32'(bus.gnt), 32'h0);
      chk("drop_c4_busy", 32'(bus.busy), 32'h0);
      chk("drop_c4_rr_ptr", 32'(dut.rr_ptr), 32'h0);
      next_cycle();
      #3 chk("drop_c5_gnt", 32'(bus.gnt), 32'h2);
      chk("drop_c5_winc", 32'(bus.winc), 32'h1);
      chk("drop_c5_wdata", 32'(bus.wdata), 32'h10);
      next_cycle();

      // Reset mid-burst: outputs clear without a clock edge.
      do_reset();
      drive(4'b0100, 4'b0000, 1'b0, 32'h00_55_00_00);
      next_cycle();
      #3 chk("rst_pre_winc", 32'(bus.winc), 32'h1);
      chk("rst_pre_busy", 32'(bus.busy), 32'h1);
      #1 wrst_n = 1'b0;
      #1;
      chk("rst_async_gnt",   32'(bus.gnt),   32'h0);
      chk("rst_async_busy",  32'(bus.busy),  32'h0);
      chk("rst_async_winc",  32'(bus.winc),  32'h0);
      chk("rst_async_ack",   32'(bus.ack),   32'h0);
      chk("rst_async_wdata", 32'(bus.wdata), 32'h0);
      drive(4'b1010, 4'b0000, 1'b0, 32'h77_00_66_00);
      @(posedge wclk);
      #1 wrst_n = 1'b1;
      #3 chk("rst_post_idle_gnt", 32'(bus.gnt), 32'h0);
      next_cycle();
      #3 chk("rst_post_gnt", 32'(bus.gnt), 32'h2);
      chk("rst_post_wdata", 32'(bus.wdata), 32'h66);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
